// File: rtl/uns_acc_pkg.sv
// Shared encodings for the unsigned integrate-and-dump accumulator.
package uns_acc_pkg;

    localparam logic [1:0] SEL_D2   = 2'b00;
    localparam logic [1:0] SEL_SUM  = 2'b01;
    localparam logic [1:0] SEL_D1   = 2'b10;
    localparam logic [1:0] SEL_ZERO = 2'b11;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/uns_acc_sel.sv
// Input selector: picks the operand added each sample, one bit wider than the
// inputs so the data1+data2 case never truncates.
module uns_acc_sel
    import uns_acc_pkg::*;
#(
    parameter int IN_W = 3
) (
    input  logic [1:0]      i_sel,
    input  logic [IN_W-1:0] i_data1,
    input  logic [IN_W-1:0] i_data2,
    output logic [IN_W:0]   o_op
);

    always_comb begin
        o_op = '0;
        case (i_sel)
            SEL_D2:  o_op = {1'b0, i_data2};
            SEL_SUM: o_op = {1'b0, i_data1} + {1'b0, i_data2};
            SEL_D1:  o_op = {1'b0, i_data1};
            default: o_op = '0;
        endcase
    end

endmodule

// File: rtl/uns_acc_dump.sv
// Unsigned integrate-and-dump accumulator with programmable window length,
// wrap/saturate mode and a sticky per-window carry flag.
module uns_acc_dump
    import uns_acc_pkg::*;
#(
    parameter int IN_W  = 3,
    parameter int ACC_W = 6,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic [IN_W-1:0]  i_data1,
    input  logic [IN_W-1:0]  i_data2,
    input  logic [1:0]       i_sel,
    input  logic             i_sat,
    input  logic [LEN_W-1:0] i_len,
    input  logic             i_clear,
    output logic [ACC_W-1:0] o_data,
    output logic             o_dump_valid,
    output logic [ACC_W-1:0] o_dump_data,
    output logic             o_dump_carry
);

    if (ACC_W < IN_W + 1) begin : g_bad_width
        $error("uns_acc_dump: ACC_W must be >= IN_W+1");
    end

    logic [IN_W:0]    w_op;
    logic [ACC_W:0]   w_sum;
    logic             w_ovf;
    logic [ACC_W-1:0] w_acc_next;
    logic             w_flag_next;
    logic             w_accept;
    logic [LEN_W-1:0] w_len_eff;
    logic [LEN_W-1:0] w_len_m1;
    logic             w_last;

    logic [ACC_W-1:0] r_acc;
    logic [LEN_W-1:0] r_count;
    logic [LEN_W-1:0] r_len;
    logic             r_flag;
    logic             r_dump_valid;
    logic [ACC_W-1:0] r_dump_data;
    logic             r_dump_carry;

    uns_acc_sel #(.IN_W(IN_W)) u_sel (
        .i_sel   (i_sel),
        .i_data1 (i_data1),
        .i_data2 (i_data2),
        .o_op    (w_op)
    );

    assign w_sum       = {1'b0, r_acc} + {{(ACC_W - IN_W){1'b0}}, w_op};
    assign w_ovf       = w_sum[ACC_W];
    assign w_acc_next  = (w_ovf && (i_sat == MODE_SAT)) ? '1 : w_sum[ACC_W-1:0];
    assign w_flag_next = r_flag | w_ovf;
    assign w_accept    = i_valid & ~i_clear;

    // The first sample of a window uses the live i_len; later ones the latched copy.
    // Length 0 wraps to all ones here, giving a 2^LEN_W-sample window.
    assign w_len_eff = (r_count == '0) ? i_len : r_len;
    assign w_len_m1  = w_len_eff - LEN_W'(1);
    assign w_last    = (r_count == w_len_m1);

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc        <= '0;
            r_count      <= '0;
            r_len        <= '0;
            r_flag       <= 1'b0;
            r_dump_valid <= 1'b0;
            r_dump_data  <= '0;
            r_dump_carry <= 1'b0;
        end else if (i_clear) begin
            r_acc        <= '0;
            r_count      <= '0;
            r_flag       <= 1'b0;
            r_dump_valid <= 1'b0;
        end else if (w_accept) begin
            if (r_count == '0) begin
                r_len <= i_len;
            end
            if (w_last) begin
                r_dump_data  <= w_acc_next;
                r_dump_carry <= w_flag_next;
                r_dump_valid <= 1'b1;
                r_acc        <= '0;
                r_count      <= '0;
                r_flag       <= 1'b0;
            end else begin
                r_acc        <= w_acc_next;
                r_count      <= r_count + LEN_W'(1);
                r_flag       <= w_flag_next;
                r_dump_valid <= 1'b0;
            end
        end else begin
            r_dump_valid <= 1'b0;
        end
    end

    assign o_data       = r_acc;
    assign o_dump_valid = r_dump_valid;
    assign o_dump_data  = r_dump_data;
    assign o_dump_carry = r_dump_carry;

endmodule

// File: tb/tb_uns_acc_dump.sv
// Directed bench for uns_acc_dump with hand-computed expectations.
module tb_uns_acc_dump;

    logic       clk = 1'b0;
    logic       i_rst_n;
    logic       i_valid;
    logic [2:0] i_data1;
    logic [2:0] i_data2;
    logic [1:0] i_sel;
    logic       i_sat;
    logic [3:0] i_len;
    logic       i_clear;
    logic [5:0] o_data;
    logic       o_dump_valid;
    logic [5:0] o_dump_data;
    logic       o_dump_carry;

    int checks   = 0;
    int failures = 0;

    uns_acc_dump #(.IN_W(3), .ACC_W(6), .LEN_W(4)) dut (
        .clk          (clk),
        .i_rst_n      (i_rst_n),
        .i_valid      (i_valid),
        .i_data1      (i_data1),
        .i_data2      (i_data2),
        .i_sel        (i_sel),
        .i_sat        (i_sat),
        .i_len        (i_len),
        .i_clear      (i_clear),
        .o_data       (o_data),
        .o_dump_valid (o_dump_valid),
        .o_dump_data  (o_dump_data),
        .o_dump_carry (o_dump_carry)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int data, input int dv,
                           input int dd, input int dc);
        chk({tag, ".data"}, 32'(o_data), data);
        chk({tag, ".dv"}, 32'(o_dump_valid), dv);
        chk({tag, ".dd"}, 32'(o_dump_data), dd);
        chk({tag, ".dc"}, 32'(o_dump_carry), dc);
    endtask

    initial begin
        // 1. reset with toggling inputs
        i_rst_n = 1'b0; i_valid = 1'b1; i_sel = 2'b01; i_data1 = 3; i_data2 = 4;
        i_sat = 1'b0; i_len = 4'd1; i_clear = 1'b0;
        cyc(); i_data1 = 7; i_len = 4'd0;
        cyc(); i_sel = 2'b10;
        cyc();
        chk_all("rst", 0, 0, 0, 0);
        i_valid = 1'b0; i_rst_n = 1'b1;
        cyc(); cyc();
        chk_all("post_rst", 0, 0, 0, 0);

        // 2. basic window, 4 x (3+4)
        i_len = 4'd4; i_sel = 2'b01; i_data1 = 3; i_data2 = 4; i_valid = 1'b1;
        cyc(); chk_all("w2.s1", 7, 0, 0, 0);
        cyc(); chk_all("w2.s2", 14, 0, 0, 0);
        cyc(); chk_all("w2.s3", 21, 0, 0, 0);
        cyc(); chk_all("w2.dump", 0, 1, 28, 0);
        i_valid = 1'b0;
        cyc(); chk_all("w2.after", 0, 0, 28, 0);

        // 3a. 16-sample window, wrap mode, 14 per sample
        i_len = 4'd0; i_data1 = 7; i_data2 = 7; i_sat = 1'b0; i_valid = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            cyc();
            if (k == 4) chk("wrap.s4", 32'(o_data), 56);
            if (k == 5) chk("wrap.s5", 32'(o_data), 6);
            chk("wrap.nodump", 32'(o_dump_valid), 0);
        end
        cyc(); chk_all("wrap.dump", 0, 1, 32, 1);

        // 3b. same window, saturate mode
        i_sat = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            cyc();
            if (k >= 5) chk("sat.pin", 32'(o_data), 63);
        end
        cyc(); chk_all("sat.dump", 0, 1, 63, 1);

        // 4. valid gaps, select data1
        i_sat = 1'b0; i_len = 4'd3; i_sel = 2'b10; i_data1 = 5;
        for (int k = 0; k < 6; k++) begin
            i_valid = (k == 0 || k == 3 || k == 5);
            if (k == 1) i_len = 4'd9;
            cyc();
            chk("gap.dv", 32'(o_dump_valid), (k == 5) ? 1 : 0);
            if (k == 0) chk("gap.s1", 32'(o_data), 5);
            if (k == 3) chk("gap.s2", 32'(o_data), 10);
        end
        chk_all("gap.dump", 0, 1, 15, 0);

        // 4b. zero select still counts samples
        i_len = 4'd2; i_sel = 2'b11; i_data1 = 7; i_data2 = 7; i_valid = 1'b1;
        cyc(); chk_all("zero.s1", 0, 0, 15, 0);
        cyc(); chk_all("zero.dump", 0, 1, 0, 0);

        // 5. mid-window length change ignored, then clear with valid
        i_len = 4'd4; i_sel = 2'b00; i_data2 = 6;
        cyc(); chk("clr.s1", 32'(o_data), 6);
        cyc(); chk("clr.s2", 32'(o_data), 12);
        i_len = 4'd2;
        cyc(); chk_all("clr.lenchg", 18, 0, 0, 0);
        i_clear = 1'b1;
        cyc(); chk_all("clr.clear", 0, 0, 0, 0);
        i_clear = 1'b0;
        cyc(); chk_all("clr.new1", 6, 0, 0, 0);
        cyc(); chk_all("clr.dump", 0, 1, 12, 0);

        // 6. back-to-back single-sample windows
        i_len = 4'd1;
        for (int k = 1; k <= 3; k++) begin
            i_data2 = 3'(k);
            cyc();
            chk_all("b2b", 0, 1, k, 0);
        end

        // 6b. async reset mid-window
        i_len = 4'd4; i_data2 = 5;
        cyc(); cyc();
        chk_all("ar.pre", 10, 0, 3, 0);
        #2 i_rst_n = 1'b0;
        #1 chk_all("ar.async", 0, 0, 0, 0);
        i_valid = 1'b0;
        cyc(); i_rst_n = 1'b1;
        cyc(); cyc();
        chk_all("ar.post", 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
